// File: rtl/cnnip_pkg.sv
// Shared types and defaults for the CNN IP memory streamer.
// cmd_t is sized to the default widths and is used wherever a whole command travels as one value.
package cnnip_pkg;

   localparam int CNNIP_ADDR_WIDTH = 20;
   localparam int CNNIP_DATA_WIDTH = 32;
   localparam int CNNIP_LEN_WIDTH  = 16;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      FIN
   } streamer_state_e;

   typedef struct packed {
      logic                        write;
      logic [CNNIP_ADDR_WIDTH-1:0] addr;
      logic [CNNIP_LEN_WIDTH-1:0]  len;
   } cmd_t;

   function automatic int be_width(input int data_width);
      return ((data_width - 1) >> 3) + 1;
   endfunction

endpackage

// File: rtl/cnnip_mem_if.sv
// Single-port word memory interface: the master drives en/we/addr/din, the slave returns dout/valid.
// Read latency is left to the slave; valid marks each returned word.
interface cnnip_mem_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = ((DATA_WIDTH - 1) >> 3) + 1;

   logic                  en;
   logic [BE_WIDTH-1:0]   we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic                  valid;

   modport master (output en, output we, output addr, output din, input dout, input valid);
   modport slave  (input en, input we, input addr, input din, output dout, output valid);

endinterface

// File: rtl/cnnip_mem_rsp_fifo.sv
// Synchronous FIFO buffering read data returned by the memory.
// A push and a pop in the same cycle are allowed at any occupancy, including full.
module cnnip_mem_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_WIDTH = $clog2(DEPTH);

   logic [WIDTH-1:0]     storage_q [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]   count_q, count_d;
   logic                 do_push, do_pop;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != (PTR_WIDTH+1)'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(do_pop);
      count_d  = count_q + (PTR_WIDTH+1)'(do_push) - (PTR_WIDTH+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         storage_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = storage_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == (PTR_WIDTH+1)'(DEPTH));
   assign count = count_q;

   always_ff @(posedge clk) begin
      if (rstn) begin
         assert (!(push && full && !pop));
      end
   end

endmodule

// File: rtl/cnnip_mem_streamer.sv
// Memory initiator: turns one (addr, len, rd/wr) command into len single-word accesses,
// fed from a write stream or delivered to a read stream through a credit-limited response FIFO.
module cnnip_mem_streamer
   import cnnip_pkg::*;
#(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   cnnip_mem_if.master           mem
);
   localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

   streamer_state_e       state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
   logic                  err_q, err_d;

   logic                  cmd_hs, wr_hs, rd_issue, rsp_accept, rsp_stray, fifo_pop;
   logic                  fifo_empty, fifo_full;
   logic [CNT_WIDTH-1:0]  fifo_count;
   logic [CNT_WIDTH:0]    credits_used;

   // Reads in flight plus buffered words never exceed the FIFO, so a return always has room.
   always_comb begin
      cmd_hs       = (state_q == IDLE) && cmd_valid;
      wr_hs        = (state_q == WRITE) && wr_valid;
      credits_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
      rd_issue     = (state_q == READ) && !fifo_full
                     && (credits_used < (CNT_WIDTH+1)'(FIFO_DEPTH));
      rsp_accept   = mem.valid && (outstanding_q != '0);
      rsp_stray    = mem.valid && (outstanding_q == '0);
      fifo_pop     = !fifo_empty && rd_ready;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_valid) begin
                     if (cmd_len == '0) state_d = FIN;
                     else               state_d = cmd_write ? WRITE : READ;
                  end
         WRITE:   if (wr_hs && remaining_q == LEN_WIDTH'(1)) state_d = FIN;
         READ:    if (rd_issue && remaining_q == LEN_WIDTH'(1)) state_d = DRAIN;
         DRAIN:   if (outstanding_q == '0 && fifo_empty) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d        = addr_q;
      remaining_d   = remaining_q;
      err_d         = err_q;
      outstanding_d = outstanding_q + CNT_WIDTH'(rd_issue) - CNT_WIDTH'(rsp_accept);
      if (cmd_hs) begin
         addr_d      = cmd_addr;
         remaining_d = cmd_len;
         err_d       = 1'b0;
      end
      if (wr_hs || rd_issue) begin
         addr_d      = addr_q + ADDR_WIDTH'(1);
         remaining_d = remaining_q - LEN_WIDTH'(1);
      end
      if (rsp_stray) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_q        <= '0;
         remaining_q   <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      cmd_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      done      = (state_q == FIN);
      wr_ready  = (state_q == WRITE);
      err       = err_q;
      mem.en    = wr_hs || rd_issue;
      mem.we    = wr_hs ? '1 : '0;
      mem.addr  = addr_q;
      mem.din   = (state_q == WRITE) ? wr_data : '0;
   end

   cnnip_mem_rsp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (rsp_accept),
      .din   (mem.dout),
      .pop   (fifo_pop),
      .dout  (rd_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign rd_valid = !fifo_empty;

endmodule
